branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised successor to the combinational branch resolver: a direct-mapped BTB plus a per-entry N-bit saturating-counter BHT.
- Gives a next-PC prediction to fetch.
- Takes resolved outcomes from execute, updates its tables and flags mispredictions so the pipeline redirects.
- Also keeps wrap-around performance counters for resolved control-flow instructions and mispredictions.

Parameters:
XLEN, 32, data/PC width
ENTRIES, 64, table depth; power of two, >= 2; IDX = log2(ENTRIES)
CTR_BITS, 2, saturating counter width; >= 1
PERF_BITS, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
f_pc  input  XLEN  fetch-stage PC being looked up
f_pred_taken  output  1  predict redirect for f_pc
f_pred_target  output  XLEN  predicted target (0 when f_pred_taken=0)
ex_valid  input  1  a control-flow instruction is resolving this cycle
ex_stall  input  1  execute stalled; suppresses update and counting
ex_kind  input  2  0=none, 1=conditional branch, 2=JAL, 3=JALR
ex_pc  input  XLEN  PC of resolving instruction
ex_taken  input  1  actual outcome (JAL/JALR: ignored, treated as 1)
ex_target  input  XLEN  actual taken target
ex_pred_taken  input  1  prediction carried down the pipe for ex_pc
ex_pred_target  input  XLEN  predicted target carried down the pipe
mispredict  output  1  redirect required this cycle
redirect_pc  output  XLEN  correct next PC when mispredict=1, else 0
perf_cf  output  PERF_BITS  count of resolved control-flow instructions
perf_miss  output  PERF_BITS  count of mispredictions

Behaviour:
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target, ctr[CTR_BITS-1:0], is_jump.
- Reset (synchronous, one cycle) clears:
  - all valid bits, ctr to weakly-not-taken (2^(CTR_BITS-1)-1), is_jump to 0;
  - perf_cf and perf_miss to 0.
- Lookup is combinational from registered tables (0-cycle latency). hit = valid && tag match.
  - f_pred_taken = hit && (is_jump || ctr MSB = 1).
  - f_pred_target = f_pred_taken ? stored target : 0.
  - Outputs with reset asserted, and in the cycle after reset: 0.
- Resolution is combinational. act = active = ex_valid && !ex_stall && ex_kind != 0 && !reset.
  - taken_eff = ex_taken for kind 1; 1 for kinds 2 and 3.
  - mispredict = act && ((taken_eff != ex_pred_taken) || (taken_eff && ex_target != ex_pred_target)).
  - redirect_pc = taken_eff ? ex_target : ex_pc + 4 (XLEN wrap); 0 when mispredict=0.
- Update happens at the clock edge when act. Indexed entry E:
  - Entry hit for ex_pc:
    - kind 1: ctr increments (saturate at all-ones) if taken, else decrements (saturate at 0).
    - If taken, target <= ex_target.
    - is_jump <= 0.
  - Miss:
    - If taken_eff: allocate (replace) E with valid=1, tag, target=ex_target.
      - ctr = weakly-taken (2^(CTR_BITS-1)).
      - is_jump = (kind != 1).
    - If not taken: no allocation.
  - kinds 2 and 3 on hit: target <= ex_target, is_jump <= 1, ctr unchanged.
- Perf counters (wrap modulo 2^PERF_BITS):
  - perf_cf += 1 when act.
  - perf_miss += 1 when mispredict.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
- ex_stall=1 or ex_kind=0: no table or counter change, mispredict=0.
- Reset asserted mid-operation overrides any update in that cycle.
- CTR_BITS=1: weakly-not-taken=0, weakly-taken=1.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0, f_pred_target=0, perf_cf=0, perf_miss=0.
- Resolve kind=1, pc=0x100, taken=1, target=0x180, pred_taken=0 -> mispredict=1, redirect_pc=0x180. Next cycle f_pc=0x100 -> pred_taken=1, target=0x180. perf_miss=1.
- Same branch then resolved not-taken twice (pred 1 then 0) -> ctr 2→1→0. First resolve: mispredict=1, redirect_pc=0x104. Lookup of 0x100 afterwards -> pred_taken=0.
- JAL at pc=0x200 → 0x40, then pc=0x200+4*ENTRIES (same index, different tag) looked up -> no hit. Resolving that alias taken replaces the entry; 0x200 now misses.
- ex_valid=1 with ex_stall=1 and a wrong prediction -> mispredict=0, tables and perf counters unchanged. Same-cycle lookup/update on index 5 returns old data.
- perf_cf preloaded near 2^PERF_BITS-1 (via PERF_BITS=4 build, 15 resolves) -> 16th resolve wraps perf_cf to 0. Reset asserted alongside a resolve -> no update, counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a per-entry saturating-counter BHT, next-PC prediction
// for fetch, misprediction detection for execute and wrap-around perf counters.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      f_pc,
  output logic                 f_pred_taken,
  output logic [XLEN-1:0]      f_pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [1:0]           ex_kind,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic                 ex_taken,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [PERF_BITS-1:0] perf_cf,
  output logic [PERF_BITS-1:0] perf_miss
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [1:0]          KIND_NONE   = 2'd0;
  localparam logic [1:0]          KIND_BRANCH = 2'd1;
  localparam logic [CTR_BITS-1:0] CTR_WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT      = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

  logic                valid_q  [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             act;
  logic             taken_eff;
  logic             unused_bits;

  assign unused_bits = ^{f_pc[1:0], ex_pc[1:0]};

  // Lookup reads the registered tables only, so a same-cycle update is not visible.
  always_comb begin
    f_idx         = f_pc[IDX+1:2];
    f_tag         = f_pc[XLEN-1:IDX+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_pred_taken  = !reset && f_hit && (jump_q[f_idx] || ctr_q[f_idx][CTR_BITS-1]);
    f_pred_target = f_pred_taken ? target_q[f_idx] : '0;
  end

  always_comb begin
    ex_idx      = ex_pc[IDX+1:2];
    ex_tag      = ex_pc[XLEN-1:IDX+2];
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    act         = ex_valid && !ex_stall && (ex_kind != KIND_NONE) && !reset;
    taken_eff   = (ex_kind == KIND_BRANCH) ? ex_taken : 1'b1;
    mispredict  = act && ((taken_eff != ex_pred_taken) ||
                          (taken_eff && (ex_target != ex_pred_target)));
    redirect_pc = '0;
    if (mispredict) redirect_pc = taken_eff ? ex_target : ex_pc + XLEN'(4);
  end

  // Tag and target are written on every taken update; on a hit the tag is unchanged.
  always_ff @(posedge clk) begin
    if (act && taken_eff) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      perf_cf   <= '0;
      perf_miss <= '0;
    end else if (act) begin
      perf_cf <= perf_cf + PERF_BITS'(1);
      if (mispredict) perf_miss <= perf_miss + PERF_BITS'(1);
      if (ex_hit) begin
        if (ex_kind == KIND_BRANCH) begin
          jump_q[ex_idx] <= 1'b0;
          if (ex_taken) begin
            if (ctr_q[ex_idx] != CTR_MAX) ctr_q[ex_idx] <= ctr_q[ex_idx] + CTR_BITS'(1);
          end else begin
            if (ctr_q[ex_idx] != '0) ctr_q[ex_idx] <= ctr_q[ex_idx] - CTR_BITS'(1);
          end
        end else begin
          jump_q[ex_idx] <= 1'b1;
        end
      end else if (taken_eff) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= CTR_WT;
        jump_q[ex_idx]  <= (ex_kind != KIND_BRANCH);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a table-of-records
// reference model using integer saturating counters.
module tb_branch_predictor;

  localparam int XLEN      = 32;
  localparam int ENTRIES   = 16;
  localparam int CTR_BITS  = 2;
  localparam int PERF_BITS = 4;
  localparam int IDX       = $clog2(ENTRIES);
  localparam int CTR_TOP   = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF  = 1 << (CTR_BITS - 1);
  localparam int PERF_MOD  = 1 << PERF_BITS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [XLEN-1:0]      f_pc = '0;
  logic                 f_pred_taken;
  logic [XLEN-1:0]      f_pred_target;
  logic                 ex_valid = 1'b0;
  logic                 ex_stall = 1'b0;
  logic [1:0]           ex_kind = 2'd0;
  logic [XLEN-1:0]      ex_pc = '0;
  logic                 ex_taken = 1'b0;
  logic [XLEN-1:0]      ex_target = '0;
  logic                 ex_pred_taken = 1'b0;
  logic [XLEN-1:0]      ex_pred_target = '0;
  logic                 mispredict;
  logic [XLEN-1:0]      redirect_pc;
  logic [PERF_BITS-1:0] perf_cf;
  logic [PERF_BITS-1:0] perf_miss;

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .PERF_BITS(PERF_BITS)
  ) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_kind(ex_kind), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_cf(perf_cf), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [31:0] tag;
    bit [31:0] target;
    int        ctr;
    bit        is_jump;
  } entry_t;

  entry_t model_tbl [ENTRIES];
  int     model_cf;
  int     model_miss;
  int     checks = 0;
  int     errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idxOf(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit [31:0] tagOf(input bit [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit modelHit(input bit [31:0] pc);
    return model_tbl[idxOf(pc)].valid && model_tbl[idxOf(pc)].tag == tagOf(pc);
  endfunction

  function automatic bit modelPred(input bit [31:0] pc);
    return modelHit(pc) && (model_tbl[idxOf(pc)].is_jump || model_tbl[idxOf(pc)].ctr >= CTR_HALF);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      model_tbl[i].valid   = 1'b0;
      model_tbl[i].ctr     = CTR_HALF - 1;
      model_tbl[i].is_jump = 1'b0;
      model_tbl[i].tag     = '0;
      model_tbl[i].target  = '0;
    end
    model_cf   = 0;
    model_miss = 0;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus(input bit rst, input bit [31:0] fpc, input bit v, input bit stall,
                               input bit [1:0] kind, input bit [31:0] pc, input bit tk,
                               input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
    bit        act, te, exp_mis, exp_pt;
    bit [31:0] exp_red;
    int        e;
    @(negedge clk);
    reset = rst; f_pc = fpc; ex_valid = v; ex_stall = stall; ex_kind = kind;
    ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    act     = v && !stall && kind != 2'd0 && !rst;
    te      = (kind == 2'd1) ? tk : 1'b1;
    exp_mis = act && (te != ptk || (te && tgt != ptgt));
    exp_red = exp_mis ? (te ? tgt : pc + 32'd4) : 32'd0;
    exp_pt  = !rst && modelPred(fpc);
    checkOutput("pred_taken", 64'(f_pred_taken), 64'(exp_pt));
    checkOutput("pred_target", 64'(f_pred_target), exp_pt ? 64'(model_tbl[idxOf(fpc)].target) : 64'd0);
    checkOutput("mispredict", 64'(mispredict), 64'(exp_mis));
    checkOutput("redirect_pc", 64'(redirect_pc), 64'(exp_red));
    checkOutput("perf_cf", 64'(perf_cf), 64'(model_cf));
    checkOutput("perf_miss", 64'(perf_miss), 64'(model_miss));
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else if (act) begin
      e = idxOf(pc);
      model_cf = (model_cf + 1) % PERF_MOD;
      if (exp_mis) model_miss = (model_miss + 1) % PERF_MOD;
      if (modelHit(pc)) begin
        if (te) model_tbl[e].target = tgt;
        if (kind == 2'd1) begin
          model_tbl[e].is_jump = 1'b0;
          if (tk && model_tbl[e].ctr < CTR_TOP) model_tbl[e].ctr++;
          if (!tk && model_tbl[e].ctr > 0) model_tbl[e].ctr--;
        end else begin
          model_tbl[e].is_jump = 1'b1;
        end
      end else if (te) begin
        model_tbl[e].valid   = 1'b1;
        model_tbl[e].tag     = tagOf(pc);
        model_tbl[e].target  = tgt;
        model_tbl[e].ctr     = CTR_HALF;
        model_tbl[e].is_jump = (kind != 2'd1);
      end
    end
  endtask

  task automatic idle(input bit [31:0] fpc);
    applyStimulus(1'b0, fpc, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bit [31:0] pc, fpc, tgt, ptgt;
    bit        ptk;
    modelReset();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(32'h100);

    // Conditional branch allocation, then two not-taken resolves draining the counter.
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b1, 32'h180, 1'b0, 32'd0);
    idle(32'h100);
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b0, 32'h180, 1'b1, 32'h180);
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b0, 32'h180, 1'b0, 32'd0);
    idle(32'h100);

    // JAL allocation, then an alias at the same index replaces it.
    applyStimulus(1'b0, 32'h200, 1'b1, 1'b0, 2'd2, 32'h200, 1'b0, 32'h40, 1'b0, 32'd0);
    idle(32'h200 + 4 * ENTRIES);
    idle(32'h200);
    applyStimulus(1'b0, 32'h200, 1'b1, 1'b0, 2'd3, 32'h200 + 4 * ENTRIES, 1'b0, 32'h80, 1'b0, 32'd0);
    idle(32'h200);
    idle(32'h200 + 4 * ENTRIES);

    // Stalled resolve with a wrong prediction must be ignored.
    applyStimulus(1'b0, 32'h200, 1'b1, 1'b1, 2'd1, 32'h300, 1'b1, 32'h999, 1'b0, 32'd0);
    idle(32'h300);
    // Same-cycle lookup and update on index 5.
    applyStimulus(1'b0, 32'h14, 1'b1, 1'b0, 2'd2, 32'h14, 1'b1, 32'h500, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h14, 1'b1, 1'b0, 2'd2, 32'h14, 1'b1, 32'h600, 1'b1, 32'h500);
    idle(32'h14);

    // Perf counter wrap after 2^PERF_BITS resolves.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < PERF_MOD; i++)
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h400 + 32'(i * 4), 1'b1, 32'h40, 1'b0, 32'd0);
    #1;
    checkOutput("perf_wrap", 64'(perf_cf), 64'd0);
    checkOutput("perf_miss_wrap", 64'(perf_miss), 64'd0);

    // Reset concurrent with an active resolve overrides the update.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h800, 1'b1, 32'h44, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h800, 1'b1, 1'b0, 2'd1, 32'h800, 1'b1, 32'h88, 1'b0, 32'd0);
    idle(32'h800);

    for (int n = 0; n < 600; n++) begin
      pc   = {($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)} | ($urandom & 3);
      fpc  = ($urandom_range(0, 1) == 1) ? pc
             : ((32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2));
      tgt  = ($urandom_range(0, 1) == 1) ? 32'h1000 : $urandom;
      ptk  = ($urandom_range(0, 3) != 0) ? modelPred(pc) : 1'($urandom);
      ptgt = ptk ? (($urandom_range(0, 3) != 0) ? model_tbl[idxOf(pc)].target : $urandom) : 32'd0;
      applyStimulus(($urandom_range(0, 59) == 0), fpc, 1'($urandom), ($urandom_range(0, 4) == 0),
                    2'($urandom), pc, 1'($urandom), tgt, ptk, ptgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
